i2c_codec_responder: RTL
========================

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A: 7-bit device address this block answers to.
REQ-002 clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl  input  1  I2C serial clock from the initiator; asynchronous to clk.
REQ-005 sda_in  input  1  sampled level of the bidirectional I2C data line; asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release the line (open-drain).
REQ-007 reg_wr_en  output  1  one-clk pulse; a complete register write was received.
REQ-008 reg_addr  output  7  codec register address; valid while reg_wr_en=1.
REQ-009 reg_data  output  9  codec register data; valid while reg_wr_en=1.
REQ-010 busy  output  1  1 from an addressed START until STOP or loss of address match.

Function
REQ-011 scl and sda_in SHALL each pass through a 2-flop synchronizer; all edge detection uses the synchronized signals.
REQ-012 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are recognized in every state.
REQ-013 Data bits SHALL be sampled on the detected SCL rising edge, MSB first.
REQ-014 States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-015 IDLE -> ADDR on START; in any other state, a START (repeated start) -> ADDR with the bit counter cleared.
REQ-016 ADDR: shift 8 bits; on the 8th bit, a match (bits[7:1]==DEV_ADDR and R/W=0) -> ACK_A; otherwise -> IGNORE.
REQ-017 ACK states: assert sda_oe on the first SCL falling edge after the 8th bit; deassert it on the next SCL falling edge, then go to the next state (ACK_A->BYTE1, ACK_1->BYTE2, ACK_2->IGNORE).
REQ-018 BYTE1 = {reg_addr[6:0], reg_data[8]}; BYTE2 = reg_data[7:0]; both use an internal shift register, and outputs update only at the write pulse.
REQ-019 reg_wr_en SHALL pulse for exactly one clk, on the clk cycle after the SCL falling edge that ends ACK_2.
REQ-020 reg_addr and reg_data hold their value after the pulse until the next write.
REQ-021 Any byte after BYTE2 SHALL be NACKed (sda_oe stays 0) and ignored until STOP or START.
REQ-022 Read requests, address mismatches and the general-call address SHALL all be NACKed; sda_oe stays 0 and the block sits in IGNORE.
REQ-023 STOP in any state -> IDLE, releases sda_oe the same cycle, and suppresses any pending or incomplete write.
REQ-024 sda_oe changes only on SCL-low phases, except at STOP/reset release.
REQ-025 busy = 1 in ADDR (after match), ACK_A through ACK_2; 0 in IDLE and IGNORE.

Reset
REQ-026 While reset=1 the block SHALL be in IDLE with sda_oe=0, reg_wr_en=0, reg_addr=0, reg_data=0, busy=0, and cleared synchronizers, bit counter and shift register.
REQ-027 Reset asserted mid-transaction SHALL abort it with no write pulse; after release, the block waits for a fresh START.

Verification
REQ-028 START, 0x34, 0x0E, 0x4A, STOP (at 40 kHz SCL) -> three ACKs; one reg_wr_en pulse with reg_addr=7'h07, reg_data=9'h04A.
REQ-029 START, 0x35 (read) -> NACK; sda_oe never 1; no pulse; busy=0.
REQ-030 START, 0x36 (wrong address), 0x0E, 0x4A, STOP -> no ACKs, no pulse.
REQ-031 START, 0x34, 0x1F, STOP -> two ACKs; STOP before BYTE2; no pulse; reg_addr and reg_data unchanged.
REQ-032 START, 0x34, 0x0C, repeated START, 0x34, 0x12, 0x01, STOP -> one pulse only, with reg_addr=7'h09, reg_data=9'h001.
REQ-033 reset=1 during ACK_1 with sda_oe=1 -> sda_oe=0 on the next clk; no pulse; the following full write completes normally.

Source files
------------

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for codec programming. It accepts an address byte and then two data
// bytes that carry a 7-bit register address and a 9-bit register value.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t     state, state_nxt;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q, byte1_q, byte_in;
  logic       ack_drive, shifting, ack_state, last_bit, addr_match;

  // p0/p1: two-flop synchronizers. p2 holds the previous synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p0 <= 1'b0; scl_p1 <= 1'b0; scl_p2 <= 1'b0;
      sda_p0 <= 1'b0; sda_p1 <= 1'b0; sda_p2 <= 1'b0;
    end else begin
      scl_p0 <= scl;    scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  always_comb begin
    scl_rise   = scl_p1 & ~scl_p2;
    scl_fall   = ~scl_p1 & scl_p2;
    start_det  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    stop_det   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    shifting   = (state == ADDR) || (state == BYTE1) || (state == BYTE2);
    ack_state  = (state == ACK_A) || (state == ACK_1) || (state == ACK_2);
    byte_in    = {shift_q[6:0], sda_p1};
    last_bit   = shifting && scl_rise && (bit_cnt == 3'd7);
    // The general-call address is rejected even if DEV_ADDR is configured as zero.
    addr_match = (byte_in[7:1] == DEV_ADDR) && (byte_in[7:1] != 7'd0) && !byte_in[0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = IDLE;
    else if (start_det) state_nxt = ADDR;
    else begin
      case (state)
        ADDR:  if (last_bit) state_nxt = addr_match ? ACK_A : IGNORE;
        BYTE1: if (last_bit) state_nxt = ACK_1;
        BYTE2: if (last_bit) state_nxt = ACK_2;
        ACK_A: if (scl_fall && ack_drive) state_nxt = BYTE1;
        ACK_1: if (scl_fall && ack_drive) state_nxt = BYTE2;
        ACK_2: if (scl_fall && ack_drive) state_nxt = IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  // Bit counter, shift registers, ACK drive and the write strobe. The strobe fires on the
  // SCL falling edge that ends the final ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      shift_q   <= 8'd0;
      byte1_q   <= 8'd0;
      ack_drive <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_addr  <= 7'd0;
      reg_data  <= 9'd0;
    end else begin
      reg_wr_en <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt   <= 3'd0;
        ack_drive <= 1'b0;
      end else begin
        if (shifting && scl_rise) begin
          shift_q <= byte_in;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == BYTE1 && last_bit) byte1_q <= byte_in;
        if (ack_state && scl_fall) ack_drive <= ~ack_drive;
        if (state == ACK_2 && scl_fall && ack_drive) begin
          reg_wr_en <= 1'b1;
          reg_addr  <= byte1_q[7:1];
          reg_data  <= {byte1_q[0], shift_q};
        end
      end
    end
  end

  always_comb begin
    sda_oe = ack_drive & ~stop_det & ~reset;
    busy   = (state == ACK_A) || (state == BYTE1) || (state == ACK_1) ||
             (state == BYTE2) || (state == ACK_2);
  end
endmodule
